// File: rtl/pc_sequencer.sv
// KGP-RISC fetch-path PC sequencer: RST_HOLD -> FETCH -> EXEC -> (FETCH | HALTED).
// Build option PC_MISALIGN_CHK_EN: a misaligned jump/branch target halts and sets misalign instead of being truncated.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_off_sh,
  input  logic        jmp,
  input  logic [31:0] jmp_tgt,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        halted,
  output logic        misalign
);

  typedef enum logic [1:0] {RST_HOLD, FETCH, EXEC, HALTED} state_t;

  state_t      r_state;
  logic        r_hold;
  logic        r_vld;
  logic [31:0] r_pc;

  logic [31:0] w_seq;
  logic [31:0] w_tgt;
  logic [31:0] w_tgt_al;
  logic        w_redirect;

  assign w_seq      = r_pc + 32'd4;
  assign w_redirect = jmp | br_taken;
  // jmp outranks br_taken when both are asserted
  assign w_tgt      = jmp ? jmp_tgt : (w_seq + br_off_sh);
  assign w_tgt_al   = w_tgt & ~32'd3;

`ifdef PC_MISALIGN_CHK_EN
  logic r_mis;
  logic w_tgt_bad;
  assign w_tgt_bad = (w_tgt != w_tgt_al);
  assign misalign  = r_mis;
`else
  assign misalign  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RST_HOLD;
      r_hold  <= 1'b1;
      r_vld   <= 1'b0;
      r_pc    <= RESET_PC;
`ifdef PC_MISALIGN_CHK_EN
      r_mis   <= 1'b0;
`endif
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        // one full idle cycle after release before the first request
        RST_HOLD: begin
          if (r_hold) r_hold  <= 1'b0;
          else        r_state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            r_state <= EXEC;
            r_vld   <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            if (halt) begin
              r_state <= HALTED;
            end else if (w_redirect) begin
`ifdef PC_MISALIGN_CHK_EN
              if (w_tgt_bad) begin
                r_state <= HALTED;
                r_mis   <= 1'b1;
              end else begin
                r_pc    <= w_tgt;
                r_state <= FETCH;
              end
`else
              r_pc    <= w_tgt_al;
              r_state <= FETCH;
`endif
            end else begin
              r_pc    <= w_seq;
              r_state <= FETCH;
            end
          end
        end
        HALTED:  r_state <= HALTED;
        default: r_state <= RST_HOLD;
      endcase
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign halted      = (r_state == HALTED);
  assign instr_valid = r_vld;
  assign pc          = r_pc;
  assign imem_addr   = r_pc;
  assign pc_plus4    = w_seq;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized instruction stream vs. a transaction-level PC model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_off_sh = '0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_tgt = '0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        halted;
  logic        misalign;

  int n_chk = 0;
  int n_err = 0;

  // reference model state: architectural PC, halted, sticky misalign
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_mis;

  pc_sequencer #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_off_sh(br_off_sh),
    .jmp(jmp), .jmp_tgt(jmp_tgt), .halt(halt), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .halted(halted), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // next-PC rules from the instruction-set view: priority halt > jmp > branch > sequential
  function automatic void model_next(input logic [31:0] p, input bit h, input bit j, input logic [31:0] t,
                                     input bit b, input logic [31:0] o,
                                     output logic [31:0] np, output bit nh, output bit nm);
    logic [31:0] tt;
    np = p + 32'd4; nh = 0; nm = 0;
    if (h) begin
      np = p; nh = 1;
    end else if (j || b) begin
      tt = j ? t : p + 32'd4 + o;
`ifdef PC_MISALIGN_CHK_EN
      if (tt % 4 != 0) begin np = p; nh = 1; nm = 1; end
      else np = tt;
`else
      np = tt - (tt % 4);
`endif
    end
  endfunction

  task automatic clear_ctl();
    halt = 0; jmp = 0; br_taken = 0; jmp_tgt = '0; br_off_sh = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; stall = 0; imem_ack = 0; clear_ctl();
    repeat (2) @(negedge clk);
    rst = 0;
    m_pc = 32'h0; m_halt = 0; m_mis = 0;
  endtask

  // Drive one instruction through FETCH/EXEC and return observed and model-predicted summaries.
  // Layout: {timeout, fetch_addr, valid_ok, stall_ok, post_pc, post_halted, post_req, misalign}
  task automatic step(input int ack_dly, input int stalls, input bit h, input bit j, input logic [31:0] t,
                      input bit b, input logic [31:0] o, output logic [69:0] act, output logic [69:0] exp_v);
    bit tmo = 1;
    logic [31:0] f_addr = 'x;
    logic vld_ok = 0, stall_ok = 1;
    logic [31:0] np; bit nh, nm;
    for (int k = 0; k < 20; k++) begin
      if (imem_req === 1'b1) begin tmo = 0; break; end
      @(negedge clk);
    end
    if (!tmo) begin
      f_addr = imem_addr;
      vld_ok = 1;
      repeat (ack_dly) begin
        @(negedge clk);
        if (instr_valid !== 1'b0 || imem_req !== 1'b1) vld_ok = 0;
      end
      imem_ack = 1;
      @(negedge clk);
      imem_ack = 0;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0) vld_ok = 0;
      if (stalls > 0) begin
        stall = 1;
        repeat (stalls) begin
          halt = 1'($urandom); jmp = 1'($urandom); br_taken = 1'($urandom);
          jmp_tgt = $urandom; br_off_sh = $urandom; imem_ack = 1'($urandom);
          @(negedge clk);
          if (pc !== f_addr || instr_valid !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b0) stall_ok = 0;
        end
        stall = 0; imem_ack = 0;
      end
      halt = h; jmp = j; jmp_tgt = t; br_taken = b; br_off_sh = o;
      @(negedge clk);
      clear_ctl();
    end
    act = {tmo, f_addr, vld_ok, stall_ok, pc, halted, imem_req, misalign};
    model_next(m_pc, h, j, t, b, o, np, nh, nm);
    exp_v = {1'b0, m_pc, 1'b1, 1'b1, np, nh, ~nh, m_mis | nm};
    m_pc = np; m_halt = nh; m_mis = m_mis | nm;
  endtask

  task automatic test_reset();
    logic [69:0] a, e;
    do_reset();
    step(0, 0, 0, 1, 32'h80, 0, 0, a, e);
    n_chk++;
    if (a !== e) begin n_err++; $display("FAIL reset_pre_jmp got=%h exp=%h", a, e); end
    @(posedge clk); #2 rst = 1; #1;
    n_chk++;
    if ({imem_req, imem_addr, pc, pc_plus4, instr_valid, halted, misalign} !== {1'b0, 32'h0, 32'h0, 32'h4, 3'b000}) begin
      n_err++;
      $display("FAIL reset_values got=%h exp=%h", {imem_req, imem_addr, pc, pc_plus4, instr_valid, halted, misalign},
               {1'b0, 32'h0, 32'h0, 32'h4, 3'b000});
    end
    @(negedge clk); rst = 0; m_pc = 0; m_mis = 0; m_halt = 0;
    @(negedge clk);
    n_chk++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL first_fetch_early got=%b exp=0", imem_req); end
    @(negedge clk);
    n_chk++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL first_fetch_req got=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h0});
    end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_ack = 1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      n_chk++;
      if (k % 2 == 0) begin
        if ({imem_req, instr_valid, imem_addr} !== {2'b10, 32'(4 * (k / 2))}) begin
          n_err++; $display("FAIL seq_fetch%0d got=%h exp=%h", k, {imem_req, instr_valid, imem_addr}, {2'b10, 32'(4 * (k / 2))});
        end
      end else begin
        if ({imem_req, instr_valid} !== 2'b01) begin
          n_err++; $display("FAIL seq_valid%0d got=%b exp=01", k, {imem_req, instr_valid});
        end
      end
      @(negedge clk);
    end
    imem_ack = 0;
  endtask

  task automatic test_branch_stall();
    logic [69:0] a, e;
    do_reset();
    step(1, 0, 0, 1, 32'h40, 0, 0, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL br_setup got=%h exp=%h", a, e); end
    step(0, 3, 0, 0, 0, 1, 32'hFFFF_FFF0, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL br_back_stall got=%h exp=%h", a, e); end
    step(2, 0, 0, 0, 0, 0, 0, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL br_next got=%h exp=%h", a, e); end
  endtask

  task automatic test_jump_wrap();
    logic [69:0] a, e;
    do_reset();
    step(0, 0, 0, 1, 32'h100, 1, 32'h20, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL jmp_over_br got=%h exp=%h", a, e); end
    step(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL jmp_top got=%h exp=%h", a, e); end
    n_chk++;
    if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL pc_plus4_wrap got=%h exp=00000000", pc_plus4); end
    step(0, 0, 0, 0, 0, 0, 0, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL seq_wrap got=%h exp=%h", a, e); end
  endtask

  task automatic test_halt();
    logic [69:0] a, e;
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL halt_setup got=%h exp=%h", a, e); end
    step(0, 2, 1, 1, 32'h200, 1, 32'h8, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL halt_prio got=%h exp=%h", a, e); end
    for (int k = 0; k < 10; k++) begin
      imem_ack = ~imem_ack;
      @(negedge clk);
      n_chk++;
      if ({imem_req, halted, instr_valid, pc} !== {3'b010, m_pc}) begin
        n_err++; $display("FAIL halt_hold%0d got=%h exp=%h", k, {imem_req, halted, instr_valid, pc}, {3'b010, m_pc});
      end
    end
    imem_ack = 0;
  endtask

  task automatic test_reset_mid_fetch();
    logic [69:0] a, e;
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL rmf_setup got=%h exp=%h", a, e); end
    imem_ack = 1;
    #2 rst = 1; #1;
    n_chk++;
    if ({imem_req, instr_valid, pc} !== {2'b00, 32'h0}) begin
      n_err++; $display("FAIL rmf_immediate got=%h exp=%h", {imem_req, instr_valid, pc}, {2'b00, 32'h0});
    end
    @(negedge clk);
    n_chk++;
    if ({imem_req, instr_valid} !== 2'b00) begin n_err++; $display("FAIL rmf_no_valid got=%b exp=00", {imem_req, instr_valid}); end
    rst = 0; m_pc = 0; m_halt = 0; m_mis = 0;
    @(negedge clk);
    n_chk++;
    if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rmf_stale_ack got=%b exp=0", instr_valid); end
    imem_ack = 0;
    step(0, 0, 0, 0, 0, 0, 0, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL rmf_refetch got=%h exp=%h", a, e); end
  endtask

  task automatic test_misalign();
    logic [69:0] a, e;
    do_reset();
    step(0, 0, 0, 1, 32'h102, 0, 0, a, e);
    n_chk++; if (a !== e) begin n_err++; $display("FAIL misalign_jmp got=%h exp=%h", a, e); end
    @(negedge clk);
    n_chk++;
    if ({misalign, halted, pc} !== {m_mis, m_halt, m_pc}) begin
      n_err++; $display("FAIL misalign_sticky got=%h exp=%h", {misalign, halted, pc}, {m_mis, m_halt, m_pc});
    end
  endtask

  task automatic test_random();
    logic [69:0] a, e;
    logic [31:0] t, o;
    bit j, b;
    do_reset();
    for (int k = 0; k < 40 && !m_halt; k++) begin
      j = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 2) == 0);
      t = $urandom & 32'hFFFF_FFFC;
      o = {{20{1'($urandom)}}, 12'($urandom)} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) t[1:0] = 2'($urandom);
      step($urandom_range(0, 3), $urandom_range(0, 2), 0, j, t, b, o, a, e);
      n_chk++;
      if (a !== e) begin n_err++; $display("FAIL rand%0d got=%h exp=%h", k, a, e); end
    end
  endtask

  initial begin
    m_pc = 0; m_halt = 0; m_mis = 0;
    test_reset();
    test_sequential();
    test_branch_stall();
    test_jump_wrap();
    test_halt();
    test_reset_mid_fetch();
    test_misalign();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the KGP-RISC fetch path, sitting directly downstream of the branch-offset left-shift-by-2 stage. It holds the architectural PC, drives an instruction-memory request/acknowledge handshake, and selects the next PC from four sources:
- sequential (PC+4)
- PC-relative branch, using the already-shifted offset
- absolute jump
- halt

It serialises fetch and next-PC decision through a small FSM, with stall and halt support.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset; must be word-aligned.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: hold the current instruction; no PC update while high.
- `br_taken` in 1: take the PC-relative branch this decision.
- `br_off_sh` in 32: branch offset, already shifted left by 2 (two's complement).
- `jmp` in 1: take the absolute jump this decision.
- `jmp_tgt` in 32: absolute jump target.
- `halt` in 1: stop fetching after the current instruction.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: memory has accepted/returned the fetch.
- `pc` out 32: PC of the current instruction.
- `pc_plus4` out 32: `pc + 4` (mod 2^32), for link/return use.
- `instr_valid` out 1: one-cycle pulse when a fetched instruction enters decision.
- `halted` out 1: sequencer is stopped.
- `misalign` out 1: sticky misaligned-target flag (see Configuration).

## Operation
- **FSM states:** RST_HOLD, FETCH, EXEC, HALTED.
- **RST_HOLD:** entered on reset. Lasts exactly one cycle after `rst` deasserts, then goes to FETCH.
- **FETCH:** `imem_req`=1. Stays in FETCH until `imem_ack`=1, then goes to EXEC.
- **EXEC:** `instr_valid`=1 in the first EXEC cycle only.
  - While `stall`=1: stay in EXEC; PC and all control inputs are ignored.
  - With `stall`=0: take the decision, update `pc`, and go to FETCH (or HALTED).
- **Decision priority in EXEC:** halt > jmp > br_taken > sequential.
  - `halt`: `pc` unchanged; go to HALTED.
  - `jmp`: `pc` ← `jmp_tgt`.
  - `br_taken`: `pc` ← `pc + 4 + br_off_sh`.
  - Otherwise: `pc` ← `pc + 4`.
- **Control sampling:** `br_taken`, `jmp` and `halt` are sampled only in a non-stalled EXEC cycle. They are don't-care in all other states.
- **Arithmetic:** all additions are 32-bit, with wrap-around and no carry-out.
  - `0xFFFF_FFFC + 4` → `0x0000_0000`.
  - Negative `br_off_sh` subtracts naturally.
- **HALTED:** `imem_req`=0 and `halted`=1. Only `rst` exits this state.
- **`imem_ack` outside FETCH:** ignored.

## Timing
- **Reset values** (asynchronous, immediate on `rst`):
  - `pc`=`imem_addr`=`RESET_PC`, `pc_plus4`=`RESET_PC+4`.
  - `imem_req`=0, `instr_valid`=0, `halted`=0, `misalign`=0.
- **Reset mid-fetch:** `imem_req` drops in the same cycle `rst` asserts. Any ack still outstanding is discarded.
- **First fetch:** `imem_req` rises in the 2nd rising edge after `rst` deasserts (one RST_HOLD cycle).
- **Latency:** `instr_valid` pulses in the cycle after the ack edge.
- **Throughput:** minimum 2 cycles per instruction (FETCH with immediate ack, then EXEC without stall).
- **PC update:** the new `pc` is visible the cycle after the deciding EXEC cycle, coincident with `imem_req` reasserting.
- **Output timing:** all outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.

## Configuration
- **`PC_MISALIGN_CHK_EN` defined:**
  - A selected jump or branch target with `[1:0]`≠0 does not update `pc`.
  - The FSM goes to HALTED and `misalign` is set.
  - `misalign` stays high until reset.
- **`PC_MISALIGN_CHK_EN` undefined:**
  - Target bits `[1:0]` are forced to 0 before loading `pc`.
  - `misalign` is tied to 0; the port always exists.

## Test plan
- **Reset and sequential run:** `RESET_PC`=0; assert then release `rst`; ack every fetch immediately → `imem_addr` sequence 0, 4, 8, 12; `instr_valid` pulses every 2nd cycle.
- **Backward branch with stall:** at `pc`=0x40, hold `stall`=1 for 3 cycles, then `br_taken`=1 with `br_off_sh`=0xFFFF_FFF0 → `pc` holds 0x40 during the stall, then becomes 0x34.
- **Jump priority and wrap:** `jmp`=1, `jmp_tgt`=0x100 and `br_taken`=1 together → `pc`=0x100. Then from `pc`=0xFFFF_FFFC sequential → `pc`=0.
- **Halt priority:** `halt`=1 with `jmp`=1 → `pc` unchanged, `halted`=1, `imem_req`=0 for 10 following cycles, with `imem_ack` toggling ignored.
- **Reset mid-fetch:** assert `rst` while in FETCH with ack pending → `imem_req`=0 the same cycle, `pc`=`RESET_PC`, and no `instr_valid` pulse.
- **Misaligned jump:** `jmp_tgt`=0x102 → with `PC_MISALIGN_CHK_EN`: `misalign`=1, `halted`=1, `pc` unchanged. Without it: `pc`=0x100 and `misalign`=0.
